// File: rtl/rcosc_clk_en_gen.sv
// Multi-channel clock-enable generator for the RC oscillator domain: per-channel divided CE pulses,
// 50% toggles and glitch-free shadowed divisor updates. Optional SYNC re-phase via RCOSC_CEGEN_SYNC_EN.
module rcosc_clk_en_gen #(
    parameter int unsigned NUM_CH  = 4,
    parameter int unsigned DIV_W   = 16,
    parameter int unsigned DIV_RST = 160,
    localparam int unsigned SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic [NUM_CH-1:0] CH_EN,
    input  logic              DIV_WR,
    input  logic [SEL_W-1:0]  DIV_SEL,
    input  logic [DIV_W-1:0]  DIV_VAL,
    output logic              DIV_ACK,
    input  logic              SYNC,
    output logic [NUM_CH-1:0] CE_OUT,
    output logic [NUM_CH-1:0] TOGGLE_OUT,
    output logic [NUM_CH-1:0] UPD_PEND
);

    localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(DIV_RST);
    localparam logic [DIV_W-1:0] RST_CNT = DIV_W'(DIV_RST - 1);

    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [DIV_W-1:0]  act_q [NUM_CH];
    logic [DIV_W-1:0]  act_d [NUM_CH];
    logic [DIV_W-1:0]  shd_q [NUM_CH];
    logic [DIV_W-1:0]  shd_d [NUM_CH];
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] ce_q, ce_d;
    logic [NUM_CH-1:0] tog_q, tog_d;
    logic              ack_q, ack_d;
    logic              sync_c;

`ifdef RCOSC_CEGEN_SYNC_EN
    assign sync_c = SYNC;
`else
    logic sync_unused;
    assign sync_unused = SYNC;
    assign sync_c      = 1'b0;
`endif

    // N of 0 and 1 both collapse to a reload of 0 (CE every cycle) without wrapping
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] n);
        return (n <= DIV_W'(1)) ? '0 : n - DIV_W'(1);
    endfunction

    // Next-state: reload/apply on disable, sync or terminal count; shadow write on top
    always_comb begin
        logic [DIV_W-1:0] apply_n;
        logic             wr_hit;
        cnt_d   = cnt_q;
        act_d   = act_q;
        shd_d   = shd_q;
        pend_d  = pend_q;
        tog_d   = tog_q;
        ce_d    = '0;
        ack_d   = DIV_WR;
        apply_n = '0;
        wr_hit  = 1'b0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            apply_n = pend_q[ch] ? shd_q[ch] : act_q[ch];
            wr_hit  = DIV_WR && (DIV_SEL == SEL_W'(ch));
            if (!CH_EN[ch] || sync_c || (cnt_q[ch] == '0)) begin
                act_d[ch]  = apply_n;
                pend_d[ch] = 1'b0;
                cnt_d[ch]  = reload_of(apply_n);
                if (!CH_EN[ch] || sync_c) begin
                    tog_d[ch] = 1'b0;
                end else begin
                    ce_d[ch]  = 1'b1;
                    tog_d[ch] = ~tog_q[ch];
                end
            end else begin
                cnt_d[ch] = cnt_q[ch] - DIV_W'(1);
            end
            if (wr_hit) begin
                shd_d[ch]  = DIV_VAL;
                pend_d[ch] = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= RST_CNT;
                act_q[ch] <= RST_DIV;
                shd_q[ch] <= RST_DIV;
            end
            pend_q <= '0;
            ce_q   <= '0;
            tog_q  <= '0;
            ack_q  <= 1'b0;
        end else begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
                act_q[ch] <= act_d[ch];
                shd_q[ch] <= shd_d[ch];
            end
            pend_q <= pend_d;
            ce_q   <= ce_d;
            tog_q  <= tog_d;
            ack_q  <= ack_d;
        end
    end

    assign CE_OUT     = ce_q;
    assign TOGGLE_OUT = tog_q;
    assign UPD_PEND   = pend_q;
    assign DIV_ACK    = ack_q;

endmodule

// File: tb/tb_rcosc_clk_en_gen.sv
// Directed bench for rcosc_clk_en_gen: 4-channel main instance plus a 3-channel instance
// used to exercise an out-of-range DIV_SEL.
module tb_rcosc_clk_en_gen;

    logic        CLK = 1'b0;
    logic        RESETN;
    logic [3:0]  ch_en;
    logic        div_wr;
    logic [1:0]  div_sel;
    logic [15:0] div_val;
    logic        div_ack;
    logic        sync;
    logic [3:0]  ce_out, tog_out, upd_pend;

    logic [2:0]  ch_en3;
    logic        div_wr3;
    logic [1:0]  div_sel3;
    logic [7:0]  div_val3;
    logic        div_ack3;
    logic [2:0]  ce3, tog3, pend3;

    int n_cmp  = 0;
    int n_fail = 0;
    int n;

    always #5 CLK = ~CLK;

    rcosc_clk_en_gen #(.NUM_CH(4), .DIV_W(16), .DIV_RST(160)) u_dut (
        .CLK(CLK), .RESETN(RESETN), .CH_EN(ch_en), .DIV_WR(div_wr), .DIV_SEL(div_sel),
        .DIV_VAL(div_val), .DIV_ACK(div_ack), .SYNC(sync), .CE_OUT(ce_out),
        .TOGGLE_OUT(tog_out), .UPD_PEND(upd_pend)
    );

    rcosc_clk_en_gen #(.NUM_CH(3), .DIV_W(8), .DIV_RST(4)) u_dut3 (
        .CLK(CLK), .RESETN(RESETN), .CH_EN(ch_en3), .DIV_WR(div_wr3), .DIV_SEL(div_sel3),
        .DIV_VAL(div_val3), .DIV_ACK(div_ack3), .SYNC(1'b0), .CE_OUT(ce3),
        .TOGGLE_OUT(tog3), .UPD_PEND(pend3)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Edges until the channel's CE is seen; -1 when the budget runs out
    task automatic wait_ce(input int ch, input bit alt, input int budget, output int cnt);
        cnt = 0;
        forever begin
            tick();
            cnt++;
            if ((alt ? ce3[ch] : ce_out[ch]) === 1'b1) break;
            if (cnt >= budget) begin
                cnt = -1;
                break;
            end
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [15:0] val);
        div_wr  = 1'b1;
        div_sel = sel;
        div_val = val;
        tick();
        div_wr  = 1'b0;
    endtask

    initial begin
        logic t;
        logic [1:0] exp_ce;
        RESETN = 1'b0; ch_en = 4'b0001; div_wr = 1'b0; div_sel = '0; div_val = '0; sync = 1'b0;
        ch_en3 = 3'b111; div_wr3 = 1'b0; div_sel3 = '0; div_val3 = '0;
        tick(); tick();
        chk("reset_outs", {ce_out, tog_out, upd_pend, 3'(div_ack)}, '0);
        RESETN = 1'b1;

        // 1) default divisor 160 on ch0
        wait_ce(0, 1'b0, 400, n);  chk("t1_first_ce", n, 160);
        chk("t1_tog_hi", tog_out[0], 1'b1);
        tick();                    chk("t1_ce_one_cycle", ce_out[0], 1'b0);
        wait_ce(0, 1'b0, 400, n);  chk("t1_second_ce", n, 159);
        chk("t1_tog_lo", tog_out[0], 1'b0);
        wait_ce(0, 1'b0, 400, n);  chk("t1_third_ce", n, 160);
        chk("t1_tog_hi2", tog_out[0], 1'b1);

        // 2) mid-period rewrite of ch1 to 4
        ch_en = 4'b0011;
        repeat (50) tick();
        wr(2'd1, 16'd4);
        chk("t2_ack", div_ack, 1'b1);
        chk("t2_pend", upd_pend[1], 1'b1);
        tick();                    chk("t2_ack_drop", div_ack, 1'b0);
        wait_ce(1, 1'b0, 400, n);  chk("t2_old_period", n, 108);
        chk("t2_pend_clr", upd_pend[1], 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_ce(1, 1'b0, 20, n); chk("t2_new_period", n, 4);
        end

        // 3) N=0 then N=1 on ch2
        wr(2'd2, 16'd0);           chk("t3_pend", upd_pend[2], 1'b1);
        tick();                    chk("t3_applied_off", upd_pend[2], 1'b0);
        ch_en[2] = 1'b1;
        t = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(); t = ~t;
            chk("t3_ce_n0", {ce_out[2], tog_out[2]}, {1'b1, t});
        end
        wr(2'd2, 16'd1); t = ~t;
        for (int i = 0; i < 6; i++) begin
            chk("t3_ce_n1", {ce_out[2], tog_out[2]}, {1'b1, t});
            tick(); t = ~t;
        end
        chk("t3_pend_n1", upd_pend[2], 1'b0);
        ch_en[2] = 1'b0;

        // 4) double write before terminal count; out-of-range select on 3-channel instance
        wait_ce(0, 1'b0, 400, n);  chk("t4_sync_ce", n > 0, 1'b1);
        wr(2'd0, 16'd10);          chk("t4_ack1", div_ack, 1'b1);
        wr(2'd0, 16'd20);          chk("t4_ack2", div_ack, 1'b1);
        chk("t4_pend", upd_pend[0], 1'b1);
        wait_ce(0, 1'b0, 400, n);  chk("t4_old_period", n, 158);
        chk("t4_pend_clr", upd_pend[0], 1'b0);
        wait_ce(0, 1'b0, 400, n);  chk("t4_last_wins", n, 20);
        wait_ce(0, 1'b0, 400, n);  chk("t4_last_wins2", n, 20);

        div_wr3 = 1'b1; div_sel3 = 2'd3; div_val3 = 8'd2;
        tick(); div_wr3 = 1'b0;
        chk("t4_oor_ack", div_ack3, 1'b1);
        chk("t4_oor_pend", pend3, 3'b000);
        tick();                    chk("t4_oor_ack_drop", div_ack3, 1'b0);
        wait_ce(0, 1'b1, 20, n);   chk("t4_oor_sync", n > 0, 1'b1);
        wait_ce(0, 1'b1, 20, n);   chk("t4_oor_period", n, 4);
        wait_ce(2, 1'b1, 20, n);   chk("t4_oor_period2", n, 4);

        // 5) ch3 N=8, disable for 50 cycles, re-enable
        wr(2'd3, 16'd8);
        tick();
        ch_en[3] = 1'b1;
        wait_ce(3, 1'b0, 50, n);   chk("t5_first", n, 8);
        wait_ce(3, 1'b0, 50, n);   chk("t5_period", n, 8);
        ch_en[3] = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(); chk("t5_off", {ce_out[3], tog_out[3]}, 2'b00);
        end
        ch_en[3] = 1'b1;
        wait_ce(3, 1'b0, 50, n);   chk("t5_reenable", n, 8);

        wr(2'd1, 16'd7);           chk("t5_pend_pre_rst", upd_pend[1], 1'b1);
        RESETN = 1'b0;
        #2;
        chk("t5_rst_outs", {ce_out, tog_out, upd_pend, 3'(div_ack)}, '0);
        ch_en = 4'b1011;
        tick();
        RESETN = 1'b1;
        wait_ce(0, 1'b0, 400, n); chk("t5_restart", n, 160);
        chk("t5_restart_all", ce_out, 4'b1011);
        chk("t5_no_pend", upd_pend, 4'b0000);

        // 6) ch0 N=3, ch1 N=5, SYNC pulse at edge 9 after enable
        ch_en = 4'b0000;
        tick();
        wr(2'd0, 16'd3);
        wr(2'd1, 16'd5);
        tick();
        ch_en = 4'b0011;
        for (int k = 1; k <= 25; k++) begin
            sync = (k == 9);
            tick();
`ifdef RCOSC_CEGEN_SYNC_EN
            exp_ce = (k <= 9) ? {1'(k % 5 == 0), 1'(k % 3 == 0)}
                              : {1'((k - 9) % 5 == 0), 1'((k - 9) % 3 == 0)};
            if (k == 9) exp_ce = 2'b00;
`else
            exp_ce = {1'(k % 5 == 0), 1'(k % 3 == 0)};
`endif
            chk("t6_sync_ce", ce_out[1:0], exp_ce);
        end
        sync = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
